// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and sends each byte as one UART frame
// (start, DATA_SIZE data bits LSB first, stop) on the tx line.
// Optional build macro UART_PARITY_EN inserts an even-parity bit between the
// last data bit and the stop bit (11-bit frame); undefined gives plain 8N1.
module fifo_uart_tx #(
   parameter int unsigned CLK_FREQ  = 100000000,
   parameter int unsigned BAUD      = 9600,
   parameter int unsigned DATA_SIZE = 8
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_data,
   output logic                 fifo_read,
   output logic                 tx,
   output logic                 busy,
   output logic                 byte_done
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_SIZE-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 rd_q, rd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;
`ifdef UART_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   assign fifo_read = rd_q;
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign byte_done = done_q;

   // State and output registers; reset parks the line high in IDLE
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         rd_q     <= rd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state, baud timing and next registered outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      rd_d     = 1'b0;
      done_d   = 1'b0;
`ifdef UART_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end  = (cnt_q == CNT_LAST);

      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               // Capture the presented byte on the same edge as the read pulse
               shift_d  = fifo_data;
               rd_d     = 1'b1;
               tx_d     = 1'b0;
               state_d  = ST_START;
`ifdef UART_PARITY_EN
               parity_d = ^fifo_data;
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                  tx_d    = parity_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            tx_d = 1'b1;
            // Registered pulse lands on the final cycle of the stop bit
            if (cnt_q == CNT_DONE) begin
               done_d = 1'b1;
            end
            if (bit_end) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at CLK_FREQ=1600, BAUD=100 (16 clocks per bit).
// Cycle-exact frame table plus a FIFO model and a UART receiver model.
module tb_fifo_uart_tx;

   localparam int CPB = 16;
`ifdef UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME_CYC = CPB * FB;

   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read, tx, busy, byte_done;

   fifo_uart_tx #(.CLK_FREQ(1600), .BAUD(100), .DATA_SIZE(8)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .tx         (tx),
      .busy       (busy),
      .byte_done  (byte_done)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: bit position in time order
   function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
      logic [FB-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_PARITY_EN
      f[9] = ^d;
`endif
      f[FB-1] = 1'b1;
      return f;
   endfunction

   // FIFO model
   bit         model_en = 1'b0;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];

   task automatic update_fifo();
      if (model_en) begin
         if (fifo_q.size() == 0) fifo_empty = 1'b1;
         else begin
            fifo_empty = 1'b0;
            fifo_data  = fifo_q[0];
         end
      end
   endtask

   task automatic tick();
      logic rd;
      rd = fifo_read;
      @(posedge clk_100MHz);
      #1;
      if (model_en && rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      update_fifo();
   endtask

   // UART receiver and handshake monitor
   int         cyc = 0;
   bit         rx_active = 1'b0;
   int         rx_cnt = 0;
   int         rx_j = 0;
   logic [7:0] rx_byte = '0;
   logic [7:0] rx_q[$];
   int         start_cyc[$];
   int         frame_err = 0;
   int         rd_count = 0;
   int         rd_bad = 0;
   int         done_count = 0;
   logic       rd_prev = 1'b0;
   logic       busy_prev = 1'b0;

   always @(posedge clk_100MHz) begin
      cyc++;
      if (reset) begin
         rx_active = 1'b0;
         rd_prev   = 1'b0;
         busy_prev = 1'b0;
      end else begin
         if (fifo_read) begin
            rd_count++;
            if (rd_prev || busy_prev) rd_bad++;
         end
         if (byte_done) done_count++;
         rd_prev   = fifo_read;
         busy_prev = busy;
         if (!rx_active) begin
            if (tx == 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
               start_cyc.push_back(cyc);
            end
         end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
               rx_j = rx_cnt / CPB;
               if (rx_j == 0) begin
                  if (tx != 1'b0) begin
                     frame_err++;
                     rx_active = 1'b0;
                  end
               end else if (rx_j <= 8) begin
                  rx_byte[rx_j-1] = tx;
               end else if (rx_j < FB - 1) begin
                  if (tx != ^rx_byte) frame_err++;
               end else begin
                  if (tx != 1'b1) frame_err++;
                  rx_q.push_back(rx_byte);
                  rx_active = 1'b0;
               end
            end
         end
      end
   end

   typedef struct {
      logic [7:0]    data;
      int            glitch;
      logic [FB-1:0] frame;
      int            done_cyc;
   } vec_t;

   vec_t vecs[7];

   // One frame from manual inputs, compared cycle by cycle with the table entry
   task automatic send_frame(input int idx, input vec_t v);
      logic [FB-1:0] first_val;
      int bad, rd_n, rd_first, done_n, done_at, busy_bad, b;
      first_val = '0;
      bad = 0; rd_n = 0; rd_first = 0; done_n = 0; done_at = -1; busy_bad = 0;
      fifo_data  = v.data;
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      for (int k = 1; k <= FRAME_CYC; k++) begin
         b = (k - 1) / CPB;
         if ((k - 1) % CPB == 0) first_val[b] = tx;
         if (tx !== v.frame[b]) bad++;
         if (fifo_read) begin
            rd_n++;
            if (k == 1) rd_first = 1;
         end
         if (byte_done) begin
            done_n++;
            done_at = k;
         end
         if (busy !== 1'b1) busy_bad++;
         if (k == v.glitch) fifo_empty = 1'b0;
         if (k == v.glitch + 1) fifo_empty = 1'b1;
         tick();
      end
      for (int i = 0; i < FB; i++)
         check($sformatf("v%0d_bit%0d", idx, i), 32'(first_val[i]), 32'(v.frame[i]));
      check($sformatf("v%0d_tx_bad_cycles", idx), bad, 0);
      check($sformatf("v%0d_read_pulses", idx), rd_n, 1);
      check($sformatf("v%0d_read_first", idx), rd_first, 1);
      check($sformatf("v%0d_done_pulses", idx), done_n, 1);
      check($sformatf("v%0d_done_cycle", idx), done_at, v.done_cyc);
      check($sformatf("v%0d_busy_bad", idx), busy_bad, 0);
      check($sformatf("v%0d_post_idle", idx), {28'd0, tx, busy, byte_done, fifo_read}, 32'h8);
   endtask

   // Drain exp_q through the FIFO model and compare the decoded stream
   task automatic drain_check(input string name);
      int n, base_rx, base_st, base_rd, base_done, base_bad, base_ferr;
      int budget, got, min_gap, gap;
      n = exp_q.size();
      base_rx = rx_q.size(); base_st = start_cyc.size(); base_rd = rd_count;
      base_done = done_count; base_bad = rd_bad; base_ferr = frame_err;
      budget = n * (FRAME_CYC + 4) + 100;
      while ((rx_q.size() - base_rx) < n && budget > 0) begin
         tick();
         budget--;
      end
      repeat (2 * FRAME_CYC) tick();
      got = rx_q.size() - base_rx;
      check({name, "_frames"}, got, n);
      for (int i = 0; i < n; i++)
         if (i < got) check($sformatf("%s_byte%0d", name, i), 32'(rx_q[base_rx+i]), 32'(exp_q[i]));
      check({name, "_reads"}, rd_count - base_rd, n);
      check({name, "_done"}, done_count - base_done, n);
      check({name, "_starts"}, start_cyc.size() - base_st, n);
      check({name, "_read_rule"}, rd_bad - base_bad, 0);
      check({name, "_frame_err"}, frame_err - base_ferr, 0);
      check({name, "_idle_after"}, {30'd0, tx, busy}, 32'h2);
      check({name, "_fifo_drained"}, fifo_q.size(), 0);
      if (start_cyc.size() - base_st >= 2) begin
         min_gap = 1 << 30;
         for (int i = base_st + 1; i < start_cyc.size(); i++) begin
            gap = start_cyc[i] - start_cyc[i-1];
            if (gap < min_gap) min_gap = gap;
         end
         check({name, "_start_gap_ge_min"}, (min_gap >= FRAME_CYC + 1) ? 32'd1 : 32'd0, 32'd1);
      end
      exp_q.delete();
   endtask

   initial begin
      int viol, base_rd;
      logic [7:0] b;
      string simon;

      vecs[0].data = 8'h41; vecs[0].glitch = 0;
      vecs[1].data = 8'h00; vecs[1].glitch = 0;
      vecs[2].data = 8'hFF; vecs[2].glitch = 0;
      vecs[3].data = 8'hA5; vecs[3].glitch = 0;
      vecs[4].data = 8'h80; vecs[4].glitch = 0;
      vecs[5].data = 8'h07; vecs[5].glitch = 0;
      vecs[6].data = 8'h5A; vecs[6].glitch = 50;
      for (int i = 0; i < 7; i++) begin
         vecs[i].frame    = frame_of(vecs[i].data);
         vecs[i].done_cyc = FRAME_CYC;
      end

      reset = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;

      // Held in reset with an empty FIFO
      viol = 0;
      repeat (200) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0 || byte_done !== 1'b0) viol++;
      end
      check("reset_hold_viol", viol, 0);
      check("reset_outputs", {28'd0, tx, busy, byte_done, fifo_read}, 32'h8);

      reset = 1'b0;
      viol = 0;
      repeat (20) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) viol++;
      end
      check("idle_empty_viol", viol, 0);

      // Cycle-exact frames, including an empty glitch mid-DATA
      for (int i = 0; i < 7; i++) begin
         send_frame(i, vecs[i]);
         repeat (3) tick();
      end

      // FIFO holding "SIMONSAI"
      model_en = 1'b1;
      simon = "SIMONSAI";
      for (int i = 0; i < 8; i++) begin
         b = simon[i];
         fifo_q.push_back(b);
         exp_q.push_back(b);
      end
      update_fifo();
      drain_check("simon");

      // Random refills after random idle gaps
      for (int burst = 0; burst < 4; burst++) begin
         repeat ($urandom_range(0, 40)) tick();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            exp_q.push_back(b);
         end
         update_fifo();
         drain_check($sformatf("rand%0d", burst));
      end
      model_en = 1'b0;
      fifo_empty = 1'b1;

      // Reset at cycle 70 of an 8'hFF frame
      fifo_data  = 8'hFF;
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      repeat (69) tick();
      check("pre_reset_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("reset_mid_outputs", {28'd0, tx, busy, byte_done, fifo_read}, 32'h8);
      base_rd = rd_count;
      tick();
      tick();
      reset = 1'b0;
      viol = 0;
      repeat (50) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) viol++;
      end
      check("after_reset_viol", viol, 0);
      check("after_reset_no_read", rd_count - base_rd, 0);

      // Recovery after the aborted frame
      vecs[0].data  = 8'h3C;
      vecs[0].frame = frame_of(8'h3C);
      send_frame(7, vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
